// File: rtl/key_accumulator.sv
// Debounced pushbutton accumulator: each accepted key press adds or subtracts
// the switch operand into a wrap-around or clamping accumulator.
module key_accumulator #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned ACC_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SATURATE        = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Accumulate_n,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic                 Mode,
  input  logic                 Clear,
  output logic [ACC_WIDTH-1:0] Acc,
  output logic [SW_WIDTH-1:0]  LED,
  output logic                 Overflow,
  output logic                 Acc_Valid,
  output logic                 Busy
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned EXT_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             key_s;
  logic             cnt_done_c;
  logic             acc_en_c;
  logic [EXT_W-1:0] sum_c;
  logic [EXT_W-1:0] diff_c;
  logic [ACC_WIDTH-1:0] result_c;
  logic             ovf_c;

  // Synchroniser stores the pressed sense so its reset value means "released"
  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], ~Accumulate_n};
  end

  assign key_s      = sync_q[1];
  assign cnt_done_c = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign acc_en_c   = (state == PRESS_WAIT) && key_s && cnt_done_c;

  // Debounce FSM; Busy is registered alongside the state it reflects
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (cnt_done_c) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_s) begin
            state <= HELD;
          end else if (cnt_done_c) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // One extra MSB captures carry-out on add and borrow on subtract
  assign sum_c  = EXT_W'(Acc) + EXT_W'(SW);
  assign diff_c = EXT_W'(Acc) - EXT_W'(SW);

  always_comb begin
    result_c = '0;
    ovf_c    = 1'b0;
    if (!Mode) begin
      ovf_c    = sum_c[ACC_WIDTH];
      result_c = sum_c[ACC_WIDTH-1:0];
      if (ovf_c && (SATURATE != 0)) result_c = {ACC_WIDTH{1'b1}};
    end else begin
      ovf_c    = diff_c[ACC_WIDTH];
      result_c = diff_c[ACC_WIDTH-1:0];
      if (ovf_c && (SATURATE != 0)) result_c = '0;
    end
  end

  // Accumulator; Clear wins over a coincident accept and suppresses Acc_Valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Acc       <= '0;
      Overflow  <= 1'b0;
      Acc_Valid <= 1'b0;
    end else begin
      Acc_Valid <= acc_en_c && !Clear;
      if (Clear) begin
        Acc      <= '0;
        Overflow <= 1'b0;
      end else if (acc_en_c) begin
        Acc <= result_c;
        if (ovf_c) Overflow <= 1'b1;
      end
    end
  end

  assign LED = Acc[SW_WIDTH-1:0];

endmodule

// File: doc/key_accumulator.md
KEY_ACCUMULATOR -- requirements
Module: key_accumulator

Interface
REQ-001 Parameters SHALL be:
- SW_WIDTH, default 8: switch operand width.
- ACC_WIDTH, default 16: accumulator width; must be at least SW_WIDTH.
- DEBOUNCE_CYCLES, default 500000: number of stable synchronised samples needed to accept a key edge; must be at least 2.
- SATURATE, default 0: 0 selects wrap mode, 1 selects clamp mode.
REQ-002 Ports SHALL be:
- Clk, input, 1: single clock.
- Reset, input, 1: synchronous, active-high.
- Accumulate_n, input, 1: raw pushbutton, asynchronous, active-low (0 = pressed).
- SW, input, SW_WIDTH: operand, sampled when an accumulate is accepted.
- Mode, input, 1: 0 = add, 1 = subtract, sampled when an accumulate is accepted.
- Clear, input, 1: synchronous, active-high accumulator clear.
- Acc, output, ACC_WIDTH: registered accumulator value.
- LED, output, SW_WIDTH: equals Acc[SW_WIDTH-1:0].
- Overflow, output, 1: sticky flag for wrap or clamp events.
- Acc_Valid, output, 1: one-cycle pulse on the cycle after Acc updates.
- Busy, output, 1: high whenever the FSM is not in IDLE.
REQ-003 Clk and Reset SHALL be the only clock and reset; the block SHALL contain no latches and no logic clocked by any other signal.

Function
REQ-004 Accumulate_n SHALL pass through a 2-flop synchroniser, then be inverted to form key_s (1 = pressed); key_s SHALL be the only form of the key used downstream.
REQ-005 The debounce FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with a counter cnt wide enough to hold DEBOUNCE_CYCLES-1.
REQ-006 IDLE: if key_s=1, go to PRESS_WAIT with cnt=0; otherwise stay in IDLE.
REQ-007 PRESS_WAIT: if key_s=0, return to IDLE; else if cnt=DEBOUNCE_CYCLES-1, go to HELD and assert the internal acc_en for exactly 1 cycle; else increment cnt.
REQ-008 HELD: if key_s=0, go to RELEASE_WAIT with cnt=0; otherwise stay in HELD. Holding the key SHALL NOT produce any further accumulate.
REQ-009 RELEASE_WAIT: if key_s=1, return to HELD with no accumulate; else if cnt=DEBOUNCE_CYCLES-1, go to IDLE; else increment cnt.
REQ-010 Each accepted press SHALL produce exactly one accumulate; a glitch shorter than DEBOUNCE_CYCLES samples SHALL produce none.
REQ-011 When acc_en is high, SW and Mode SHALL be sampled on that cycle and Acc SHALL update on the next edge.
REQ-012 The operand SHALL be SW zero-extended to ACC_WIDTH; the result SHALL be Acc+operand when Mode=0 and Acc-operand when Mode=1.
REQ-013 Wrap mode (SATURATE=0): the result SHALL be taken modulo 2^ACC_WIDTH, and Overflow SHALL be set on any carry-out (add) or borrow (subtract).
REQ-014 Clamp mode (SATURATE=1): an add SHALL clamp at 2^ACC_WIDTH-1 and a subtract SHALL clamp at 0, and Overflow SHALL be set whenever a clamp occurs.
REQ-015 Overflow SHALL stay set until Clear or Reset.
REQ-016 Clear=1 SHALL set Acc=0 and Overflow=0 on the next edge, SHALL take priority over a simultaneous acc_en (that accumulate is discarded), and SHALL NOT affect the FSM state or cnt.
REQ-017 Acc_Valid SHALL pulse high for 1 cycle on the cycle after each accumulate update, and SHALL NOT pulse for a Clear.
REQ-018 Latency from the first pressed sample at Accumulate_n to the Acc update SHALL be 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-019 While Reset=1, on each edge: FSM=IDLE, cnt=0, synchroniser flops=0 (released), Acc=0, Overflow=0, Acc_Valid=0, Busy=0.
REQ-020 Reset asserted mid-debounce or mid-hold SHALL abort without any accumulate; after release, a still-held key SHALL be treated as a new press.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=8, ACC_WIDTH=8 unless stated)
REQ-021 Two clean presses with SW=0x05, Mode=0 -> Acc 0x05 then 0x0A; Acc_Valid pulses exactly twice; Overflow=0.
REQ-022 Press with a 3-cycle low glitch, then key released -> Acc unchanged, Acc_Valid never pulses, Busy returns to 0.
REQ-023 Wrap mode: Acc=0xFE, add SW=0x03 -> Acc=0x01, Overflow=1; then Clear -> Acc=0x00, Overflow=0.
REQ-024 SATURATE=1: Acc=0x02, subtract SW=0x05 -> Acc=0x00, Overflow=1; then Acc=0xFD, add SW=0x10 -> Acc=0xFF.
REQ-025 Clear asserted on the same cycle as acc_en, with Acc=0x20, SW=0x01 -> Acc=0x00 and no Acc_Valid pulse.
REQ-026 Key held for 100 cycles, with Reset pulsed for 1 cycle in the middle of HELD -> the held key is re-accepted as a new press after reset release: Acc=SW and exactly one Acc_Valid pulse after the reset.
